// File: rtl/mem_byte_engine_pkg.sv
// Shared constants for the cache-to-memory byte engine: request size codes,
// I/O region selector, FSM state encoding and read-data extension helper.
package mem_pkg;

  // len[1:0] size codes; len[LEN_SIGNED] requests sign extension on reads
  localparam logic [1:0]  LEN_BYTE   = 2'd0;
  localparam logic [1:0]  LEN_HALF   = 2'd1;
  localparam logic [1:0]  LEN_WORD   = 2'd2;
  localparam int unsigned LEN_SIGNED = 2;

  // addr[17:16] value selecting the I/O region
  localparam logic [1:0]  IO_SEL     = 2'b11;

  // FSM state encoding
  localparam logic [1:0]  IDLE       = 2'd0;
  localparam logic [1:0]  READ       = 2'd1;
  localparam logic [1:0]  WRITE      = 2'd2;

  // Index of the final byte of a transfer; size code 3 behaves as a word
  function automatic logic [1:0] last_byte(input logic [1:0] size);
    case (size)
      LEN_BYTE: last_byte = 2'd0;
      LEN_HALF: last_byte = 2'd1;
      default:  last_byte = 2'd3;
    endcase
  endfunction

  // Zero- or sign-fill the bytes above the transfer size
  function automatic logic [31:0] extend_read(input logic [31:0] raw,
                                              input logic [2:0]  len);
    logic fill;
    fill = 1'b0;
    case (len[1:0])
      LEN_BYTE: begin
        fill        = len[LEN_SIGNED] & raw[7];
        extend_read = {{24{fill}}, raw[7:0]};
      end
      LEN_HALF: begin
        fill        = len[LEN_SIGNED] & raw[15];
        extend_read = {{16{fill}}, raw[15:0]};
      end
      default: extend_read = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_engine.sv
// Responder side of the cache-to-memory request interface. Accepts one
// byte/half/word request and serialises it over the 8-bit RAM/IO bus,
// returning a one-cycle ready pulse (with read data) on completion.
module mem_byte_engine #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [1:0]  IO_SEL = mem_pkg::IO_SEL
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              io_buffer_full,
  input  logic              waiting,
  input  logic              wr,
  input  logic [2:0]        len,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       value,
  output logic              ready,
  output logic [31:0]       result,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  import mem_pkg::*;

  logic [1:0]        state_q,    state_d;
  logic [1:0]        cnt_q,      cnt_d;
  logic              prime_q,    prime_d;
  logic              flush_q,    flush_d;
  logic [ADDR_W-1:0] base_q,     base_d;
  logic [2:0]        len_q,      len_d;
  logic [31:0]       wdata_q,    wdata_d;
  logic [31:0]       asm_q,      asm_d;
  logic [31:0]       result_q,   result_d;
  logic              ready_q,    ready_d;
  logic [ADDR_W-1:0] mem_a_q,    mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              mem_wr_q,   mem_wr_d;

  logic [1:0] last_idx;
  logic [1:0] cnt_inc;
  logic       io_stall;

  assign last_idx = last_byte(len_q[1:0]);
  assign cnt_inc  = cnt_q + 2'd1;
  // Only write cycles are gated by the buffer; mem_wr_q is low outside WRITE
  assign io_stall = (base_q[17:16] == IO_SEL) && io_buffer_full;

  assign ready    = ready_q;
  assign result   = result_q;
  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy_in & ~io_stall;

  // Next-state logic: request acceptance, read capture, write sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prime_d    = prime_q;
    flush_d    = flush_q;
    base_d     = base_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    result_d   = result_q;
    ready_d    = 1'b0;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;

    case (state_q)
      IDLE: begin
        if (!clear_in && waiting && !ready_q) begin
          base_d  = addr;
          len_d   = len;
          wdata_d = value;
          cnt_d   = 2'd0;
          flush_d = 1'b0;
          mem_a_d = addr;
          if (wr) begin
            state_d    = WRITE;
            mem_dout_d = value[7:0];
            mem_wr_d   = 1'b1;
          end else begin
            state_d = READ;
            prime_d = 1'b1;
            asm_d   = '0;
          end
        end
      end

      // The first READ cycle only issues byte 0's address; each later cycle
      // captures byte cnt_q while the address two bytes ahead is driven.
      READ: begin
        if (clear_in) begin
          state_d = IDLE;
        end else if (prime_q) begin
          prime_d = 1'b0;
          if (last_idx != 2'd0)
            mem_a_d = base_q + ADDR_W'(1);
        end else begin
          asm_d[{cnt_q, 3'b000} +: 8] = mem_din;
          if (cnt_q == last_idx) begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            result_d = extend_read(asm_d, len_q);
          end else begin
            cnt_d = cnt_inc;
            if (({1'b0, cnt_q} + 3'd2) <= {1'b0, last_idx})
              mem_a_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(2);
          end
        end
      end

      // A flush during a write lets the store finish but drops its ready
      WRITE: begin
        if (clear_in)
          flush_d = 1'b1;
        if (!io_stall) begin
          if (cnt_q == last_idx) begin
            state_d  = IDLE;
            mem_wr_d = 1'b0;
            ready_d  = !(flush_q || clear_in);
          end else begin
            cnt_d      = cnt_inc;
            mem_a_d    = base_q + ADDR_W'(cnt_inc);
            mem_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
          end
        end
      end

      default: begin
        state_d  = IDLE;
        mem_wr_d = 1'b0;
      end
    endcase
  end

  // State registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prime_q    <= 1'b0;
      flush_q    <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prime_q    <= prime_d;
      flush_q    <= flush_d;
      base_q     <= base_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

endmodule
